// File: rtl/onchip_mem_bist_master.sv
// onchip_mem_bist_master: Avalon-MM RAM self-test master that writes a pattern, reads it back and counts mismatches.
// Define MEM_BIST_LFSR_EN to take data from a 32-bit Galois LFSR instead of the address-XOR pattern.
module onchip_mem_bist_master #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 5000,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q, first_q;
  logic [DATA_W-1:0]  seed_q, seed_d, pat_d;
  logic [ERR_W-1:0]   err_q;
  logic               wr_q, rd_q, busy_q, done_q, pass_q;
  logic               acc_d, last_d, mis_d;
  // Read-return pipe: valid flag, address and expected data per outstanding read
  logic [READ_LATENCY-1:0] vld_q;
  logic [ADDR_W-1:0]       pa_q [READ_LATENCY];
  logic [DATA_W-1:0]       pd_q [READ_LATENCY];

`ifdef MEM_BIST_LFSR_EN
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? DATA_W'(32'h80200003) : '0);
  assign pat_d  = lfsr_q;
  assign seed_d = (seed == '0) ? DATA_W'(1) : seed;
`else
  assign pat_d  = seed_q ^ DATA_W'(addr_q) ^ (DATA_W'(addr_q) << 16);
  assign seed_d = seed;
`endif

  assign acc_d  = (wr_q | rd_q) & ~avm_waitrequest;
  assign last_d = addr_q == ADDR_W'(DEPTH - 1);
  assign mis_d  = vld_q[READ_LATENCY-1] && (avm_readdata != pd_q[READ_LATENCY-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      first_q <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pa_q[i] <= '0;
        pd_q[i] <= '0;
      end
`ifdef MEM_BIST_LFSR_EN
      lfsr_q  <= '0;
`endif
    end else begin
      vld_q[0] <= rd_q & ~avm_waitrequest;
      pa_q[0]  <= addr_q;
      pd_q[0]  <= pat_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        pa_q[i]  <= pa_q[i-1];
        pd_q[i]  <= pd_q[i-1];
      end
      if (mis_d) begin
        if (err_q != '1) err_q <= err_q + 1'b1;
        if (err_q == '0) first_q <= pa_q[READ_LATENCY-1];
      end
      case (state_q)
        IDLE, DONE: if (start) begin
          seed_q  <= seed_d;
          err_q   <= '0;
          first_q <= '0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          busy_q  <= 1'b1;
          addr_q  <= '0;
          wr_q    <= 1'b1;
          state_q <= WRITE;
`ifdef MEM_BIST_LFSR_EN
          lfsr_q  <= seed_d;
`endif
        end
        WRITE: if (acc_d) begin
          if (last_d) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b1;
            state_q <= READ;
`ifdef MEM_BIST_LFSR_EN
            lfsr_q  <= seed_q;
`endif
          end else begin
            addr_q  <= addr_q + 1'b1;
`ifdef MEM_BIST_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
          end
        end
        READ: if (acc_d) begin
`ifdef MEM_BIST_LFSR_EN
          lfsr_q <= lfsr_d;
`endif
          if (last_d) begin
            addr_q  <= '0;
            rd_q    <= 1'b0;
            state_q <= DRAIN;
          end else addr_q <= addr_q + 1'b1;
        end
        // Pipe empty means the last return has already been compared
        DRAIN: if (vld_q == '0) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= err_q == '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign avm_address    = addr_q;
  assign avm_write      = wr_q;
  assign avm_read       = rd_q;
  assign avm_chipselect = wr_q | rd_q;
  assign avm_byteenable = {(DATA_W/8){wr_q | rd_q}};
  assign avm_writedata  = wr_q ? pat_d : '0;
endmodule

// File: doc/onchip_mem_bist_master.md
Name: onchip_mem_bist_master

Overview:
- Avalon-MM master that drives the system's single-port on-chip RAM slave, which has 13-bit word address, 32-bit data, 4-bit byteenable and a fixed 1-cycle read latency.
- On a start request it writes a deterministic pattern to every word, reads every word back, compares, and reports pass/fail, error count and first failing address.
- Sits beside the CPU on the interconnect as a power-up/self-test initiator.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 5000, number of words tested, addresses 0..DEPTH-1.
- READ_LATENCY, 1, fixed cycles from accepted read to valid avm_readdata. Legal range 1..4.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a test.
- seed  in  DATA_W  pattern seed, sampled on an accepted start.
- busy  out  1  high from accepted start until done rises.
- done  out  1  test complete; held until the next accepted start.
- pass  out  1  done and err_count==0.
- err_count  out  ERR_W  number of mismatching words; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if there is none.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  DATA_W/8  always all-ones during a transfer, 0 otherwise.
- avm_chipselect  out  1  high with avm_write or avm_read.
- avm_write  out  1  write request.
- avm_read  out  1  read request.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  read data.
- avm_waitrequest  in  1  slave stall. Tie to 0 for the bare RAM.

Behaviour:
- Reset (async assert, sync deassert handled externally): state IDLE. All outputs 0. Counters and the latency pipe are cleared. A reset during a test aborts it with no partial result and no further bus requests.
- States:
  - IDLE: wait for start. busy=0.
  - WRITE: addr from 0 to DEPTH-1.
  - READ: addr from 0 to DEPTH-1.
  - DRAIN: collect the outstanding read returns.
  - DONE: results valid.
- Start handling:
  - start is accepted in IDLE or DONE.
  - On acceptance: latch seed, clear err_count, first_err_addr, done and pass, set busy, go to WRITE.
  - start is ignored while busy.
- Transfer acceptance: a transfer is accepted on a clk edge with request high and avm_waitrequest=0. While avm_waitrequest=1, address, writedata and the control signals are held stable.
- WRITE phase:
  - One write per cycle when not stalled; addr increments per accepted write.
  - After the write to DEPTH-1 is accepted, go to READ with addr=0. No idle cycle in between.
- READ phase:
  - Pipelined reads, one per cycle when not stalled.
  - Each accepted read pushes {addr, expected data} into a READ_LATENCY-deep shift register.
  - The stage emerging READ_LATENCY cycles later is compared with avm_readdata.
  - After the read of DEPTH-1 is accepted, go to DRAIN.
- DRAIN: lasts READ_LATENCY cycles, then DONE. Set done=1, busy=0, pass=(err_count==0).
- Compare:
  - On mismatch: err_count increments, saturating.
  - On the first mismatch only, first_err_addr is captured.
  - Errors in the last returning word must be counted before done rises.
- Default pattern: pattern(a) = seed ^ a ^ (a<<16), with a zero-extended to DATA_W.
- Timing with no stalls: start sampled at edge T.
  - First write visible in cycle T+1.
  - Writes occupy DEPTH cycles, then reads occupy DEPTH cycles.
  - done rises at edge T+1+2*DEPTH+READ_LATENCY.
- Address wrap: addr never exceeds DEPTH-1. DEPTH=1 must work.

Optional Feature:
- MEM_BIST_LFSR_EN defined:
  - Data come from a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded with seed; seed 0 is replaced by 1.
  - The LFSR advances once per accepted write.
  - It is reloaded with the same seed at the WRITE-to-READ transition and advances once per accepted read, so expected data track the read order.
- Not defined: the address-XOR pattern above; no LFSR logic is synthesized.

Test Plan:
- DEPTH=8, seed=0xA5A50000, ideal RAM model, start pulse at T -> writes to addr 0..7 in T+1..T+8. addr 3 data=0xA5A60003. done and pass=1 at T+18, err_count=0.
- Same setup, model forces addr 5 read bit0 flipped -> err_count=1, first_err_addr=5, pass=0.
- Model stuck-at-0 data for addr 2 and 6 -> err_count=2, first_err_addr=2.
- avm_waitrequest toggled pseudo-randomly -> signals held stable while stalled. Exactly 8 writes and 8 reads accepted, pass=1.
- start pulsed again mid-test, then reset_n low at the 4th read, then start -> extra start ignored. All bus outputs 0 during reset. The new test passes with fresh counts.
- MEM_BIST_LFSR_EN defined, seed=0 -> first write data=0x00000001, pass=1.
